// File: rtl/audio_sample_scheduler.sv
// Audio sample scheduler for an HDMI transmitter running on the pixel clock.
//
// A phase accumulator divides clk_pixel down to the audio sample rate with no
// long-term drift. Each sample period produces one sample_strobe pulse and one
// ~50% duty clk_audio cycle. A small FIFO buffers stereo samples from the
// producer, and one entry is popped into audio_left/audio_right on every strobe.
//
// Ports:
//   clk_pixel       in   sole clock, rising edge
//   reset           in   synchronous active-high reset
//   wr_valid        in   producer offers a stereo sample
//   wr_ready        out  FIFO can accept (fill_level < DEPTH), combinational
//   wr_left/right   in   sample words, captured when wr_valid && wr_ready
//   mute            in   zero the output words from the next strobe on
//   sample_strobe   out  one-cycle pulse per audio sample period
//   clk_audio       out  registered ~50% duty sample clock
//   audio_left/right out registered current sample
//   fill_level      out  FIFO occupancy
//   underrun_count  out  saturating count of strobes that found the FIFO empty
module audio_sample_scheduler #(
  parameter int unsigned CLK_HZ      = 74250000,
  parameter int unsigned SAMPLE_RATE = 48000,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned BIT_WIDTH   = 16
) (
  input  logic                   clk_pixel,
  input  logic                   reset,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [BIT_WIDTH-1:0]   wr_left,
  input  logic [BIT_WIDTH-1:0]   wr_right,
  input  logic                   mute,
  output logic                   sample_strobe,
  output logic                   clk_audio,
  output logic [BIT_WIDTH-1:0]   audio_left,
  output logic [BIT_WIDTH-1:0]   audio_right,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic [7:0]             underrun_count
);

  localparam int unsigned AW = $clog2(CLK_HZ) + 1;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned FW = PW + 1;

  localparam logic [AW-1:0] ClkHzC  = AW'(CLK_HZ);
  localparam logic [AW-1:0] HalfC   = AW'(CLK_HZ / 2);
  localparam logic [AW-1:0] StepC   = AW'(SAMPLE_RATE);
  localparam logic [FW-1:0] DepthC  = FW'(DEPTH);

  // Phase accumulator
  logic [AW-1:0] acc_q;
  logic [AW-1:0] acc_nxt;
  logic [AW-1:0] acc_d;
  logic          strobe_now;

  always_comb begin
    acc_nxt    = acc_q + StepC;
    strobe_now = (acc_nxt >= ClkHzC);
    acc_d      = strobe_now ? (acc_nxt - ClkHzC) : acc_nxt;
  end

  // FIFO storage, {left, right} per entry
  logic [2*BIT_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]          wr_ptr_q;
  logic [PW-1:0]          rd_ptr_q;
  logic [FW-1:0]          fill_d;
  logic                   push;
  logic                   pop;

  // wr_ready reflects occupancy before this cycle's pop, so a full FIFO never
  // accepts a write in the same cycle a strobe frees a slot.
  assign wr_ready = (fill_level < DepthC);
  assign push     = wr_valid && wr_ready;
  // A strobe into an empty FIFO is an underrun even if a push lands this cycle.
  assign pop      = strobe_now && (fill_level != '0);

  always_comb begin
    fill_d = fill_level;
    case ({push, pop})
      2'b10:   fill_d = fill_level + FW'(1);
      2'b01:   fill_d = fill_level - FW'(1);
      default: fill_d = fill_level;
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {wr_left, wr_right};
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      acc_q          <= '0;
      sample_strobe  <= 1'b0;
      clk_audio      <= 1'b0;
      audio_left     <= '0;
      audio_right    <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fill_level     <= '0;
      underrun_count <= '0;
    end else begin
      acc_q         <= acc_d;
      sample_strobe <= strobe_now;
      // Low from the strobe edge, high once the phase passes half a period.
      clk_audio     <= (acc_d >= HalfC);
      fill_level    <= fill_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      // Output words only move on the strobe edge, so mute never cuts a sample.
      if (strobe_now) begin
        if (mute) begin
          audio_left  <= '0;
          audio_right <= '0;
        end else if (pop) begin
          {audio_left, audio_right} <= mem_q[rd_ptr_q];
        end
        if (!pop && (underrun_count != 8'hFF)) begin
          underrun_count <= underrun_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_sample_scheduler.sv
module tb_audio_sample_scheduler;

  logic        clk_pixel;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_left;
  logic [15:0] wr_right;
  logic        mute;
  logic        sample_strobe;
  logic        clk_audio;
  logic [15:0] audio_left;
  logic [15:0] audio_right;
  logic [3:0]  fill_level;
  logic [7:0]  underrun_count;

  // Fast-ratio instance: strobe every 8 cycles, depth 4
  logic        f_reset;
  logic        f_valid;
  logic        f_ready;
  logic [15:0] f_left;
  logic [15:0] f_right;
  logic        f_mute;
  logic        f_strobe;
  logic        f_clk_audio;
  logic [15:0] f_aleft;
  logic [15:0] f_aright;
  logic [2:0]  f_fill;
  logic [7:0]  f_under;

  int checks = 0;
  int fails  = 0;
  int strobe_tbl [8] = '{1547, 3094, 4641, 6188, 7735, 9282, 10829, 12375};

  audio_sample_scheduler dut (
    .clk_pixel      (clk_pixel),
    .reset          (reset),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_left        (wr_left),
    .wr_right       (wr_right),
    .mute           (mute),
    .sample_strobe  (sample_strobe),
    .clk_audio      (clk_audio),
    .audio_left     (audio_left),
    .audio_right    (audio_right),
    .fill_level     (fill_level),
    .underrun_count (underrun_count)
  );

  audio_sample_scheduler #(
    .CLK_HZ      (64),
    .SAMPLE_RATE (8),
    .DEPTH       (4),
    .BIT_WIDTH   (16)
  ) dut_fast (
    .clk_pixel      (clk_pixel),
    .reset          (f_reset),
    .wr_valid       (f_valid),
    .wr_ready       (f_ready),
    .wr_left        (f_left),
    .wr_right       (f_right),
    .mute           (f_mute),
    .sample_strobe  (f_strobe),
    .clk_audio      (f_clk_audio),
    .audio_left     (f_aleft),
    .audio_right    (f_aright),
    .fill_level     (f_fill),
    .underrun_count (f_under)
  );

  initial begin
    clk_pixel = 1'b0;
    forever #5 clk_pixel = ~clk_pixel;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk_pixel);
    #1;
  endtask

  function automatic logic [15:0] pat(input int k);
    return 16'(k * 32'h1111);
  endfunction

  // Returns ticks until sample_strobe is seen; limit+1 on timeout.
  task automatic wait_strobe(input int limit, output int n);
    tick();
    n = 1;
    while (!sample_strobe && n <= limit) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_fstrobe(input int limit, output int n);
    tick();
    n = 1;
    while (!f_strobe && n <= limit) begin
      tick();
      n++;
    end
  endtask

  task automatic push_eight;
    for (int k = 1; k <= 8; k++) begin
      wr_valid = 1'b1;
      wr_left  = pat(k);
      wr_right = ~pat(k);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; f_reset = 1'b1; wr_valid = 1'b0; f_valid = 1'b0;
    wr_left = '0; wr_right = '0; f_left = '0; f_right = '0; mute = 1'b0; f_mute = 1'b0;
    tick();
    tick();
    checks++;
    if (sample_strobe !== 1'b0 || clk_audio !== 1'b0) begin
      fails++; $display("FAIL reset_strobe_clk: got %b/%b want 0/0", sample_strobe, clk_audio);
    end
    checks++;
    if (audio_left !== 16'h0 || audio_right !== 16'h0) begin
      fails++; $display("FAIL reset_audio: got %h/%h want 0/0", audio_left, audio_right);
    end
    checks++;
    if (fill_level !== 4'd0 || underrun_count !== 8'd0) begin
      fails++; $display("FAIL reset_counts: got %0d/%0d want 0/0", fill_level, underrun_count);
    end
    checks++;
    if (wr_ready !== 1'b1) begin
      fails++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_free_run;
    int   ns, rise_n, rise1, rise2, ready_bad;
    int   sc [8];
    logic prev_ca, ca_s1;
    ns = 0; rise_n = 0; rise1 = 0; rise2 = 0; ready_bad = 0; ca_s1 = 1'b1;
    for (int i = 0; i < 8; i++) sc[i] = 0;
    prev_ca = clk_audio;
    for (int c = 1; c <= 12375; c++) begin
      tick();
      if (!wr_ready) ready_bad++;
      if (sample_strobe) begin
        if (ns < 8) sc[ns] = c;
        if (ns == 0) ca_s1 = clk_audio;
        ns++;
      end
      if (clk_audio && !prev_ca) begin
        if (rise_n == 0) rise1 = c;
        if (rise_n == 1) rise2 = c;
        rise_n++;
      end
      prev_ca = clk_audio;
    end
    checks++;
    if (ns !== 8) begin
      fails++; $display("FAIL free_run_strobes: got %0d want 8", ns);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (sc[i] !== strobe_tbl[i]) begin
        fails++; $display("FAIL free_run_strobe_cycle[%0d]: got %0d want %0d", i, sc[i],
                          strobe_tbl[i]);
      end
    end
    checks++;
    if (ca_s1 !== 1'b0) begin
      fails++; $display("FAIL clk_audio_at_strobe: got %b want 0", ca_s1);
    end
    checks++;
    if (rise1 !== 774 || rise2 !== 2321 || rise_n !== 8) begin
      fails++; $display("FAIL clk_audio_rises: got %0d,%0d n=%0d want 774,2321 n=8", rise1,
                        rise2, rise_n);
    end
    checks++;
    if (underrun_count !== 8'd8) begin
      fails++; $display("FAIL free_run_underruns: got %0d want 8", underrun_count);
    end
    checks++;
    if (audio_left !== 16'h0 || audio_right !== 16'h0 || ready_bad !== 0) begin
      fails++; $display("FAIL free_run_outputs: got %h/%h ready_bad=%0d want 0/0/0", audio_left,
                        audio_right, ready_bad);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      wr_valid = 1'b1;
      wr_left  = pat(k);
      wr_right = ~pat(k);
      checks++;
      if (wr_ready !== 1'b1) begin
        fails++; $display("FAIL b2b_ready_before_push%0d: got %b want 1", k, wr_ready);
      end
      tick();
    end
    wr_valid = 1'b0;
    checks++;
    if (wr_ready !== 1'b0 || fill_level !== 4'd8) begin
      fails++; $display("FAIL b2b_full: got ready=%b fill=%0d want 0/8", wr_ready, fill_level);
    end
    for (int i = 1; i <= 8; i++) begin
      wait_strobe(2000, n);
      if (i == 1) begin
        checks++;
        if (n !== 1539) begin
          fails++; $display("FAIL b2b_first_strobe_delay: got %0d want 1539", n);
        end
      end
      checks++;
      if (audio_left !== pat(i) || audio_right !== ~pat(i) || fill_level !== 4'(8 - i)) begin
        fails++; $display("FAIL b2b_pop%0d: got %h/%h fill=%0d want %h/%h fill=%0d", i,
                          audio_left, audio_right, fill_level, pat(i), ~pat(i), 8 - i);
      end
      if (i == 1) begin
        tick();
        checks++;
        if (sample_strobe !== 1'b0 || audio_left !== pat(1)) begin
          fails++; $display("FAIL b2b_hold_after_strobe: got %b/%h want 0/%h", sample_strobe,
                            audio_left, pat(1));
        end
      end
    end
    checks++;
    if (underrun_count !== 8'd0 || fill_level !== 4'd0 || wr_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_end: got under=%0d fill=%0d ready=%b want 0/0/1",
                        underrun_count, fill_level, wr_ready);
    end
  endtask

  task automatic test_full_hold;
    int n;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push_eight();
    wr_valid = 1'b1;
    wr_left  = 16'hAAAA;
    wr_right = 16'h5555;
    wait_strobe(2000, n);
    checks++;
    if (n !== 1539 || fill_level !== 4'd7 || wr_ready !== 1'b1 || audio_left !== 16'h1111) begin
      fails++; $display("FAIL full_hold_pop: got n=%0d fill=%0d ready=%b L=%h want 1539/7/1/1111",
                        n, fill_level, wr_ready, audio_left);
    end
    tick();
    checks++;
    if (fill_level !== 4'd8 || wr_ready !== 1'b0) begin
      fails++; $display("FAIL full_hold_push: got fill=%0d ready=%b want 8/0", fill_level,
                        wr_ready);
    end
    repeat (3) tick();
    checks++;
    if (fill_level !== 4'd8) begin
      fails++; $display("FAIL full_hold_single_push: got fill=%0d want 8", fill_level);
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_mute;
    int n;
    repeat (700) tick();
    mute = 1'b1;
    tick();
    checks++;
    if (audio_left !== 16'h1111 || audio_right !== 16'hEEEE) begin
      fails++; $display("FAIL mute_mid_period: got %h/%h want 1111/eeee", audio_left,
                        audio_right);
    end
    wait_strobe(2000, n);
    checks++;
    if (audio_left !== 16'h0 || audio_right !== 16'h0 || fill_level !== 4'd7) begin
      fails++; $display("FAIL mute_strobe: got %h/%h fill=%0d want 0/0 fill=7", audio_left,
                        audio_right, fill_level);
    end
    repeat (700) tick();
    mute = 1'b0;
    tick();
    checks++;
    if (audio_left !== 16'h0) begin
      fails++; $display("FAIL unmute_mid_period: got %h want 0", audio_left);
    end
    wait_strobe(2000, n);
    checks++;
    if (audio_left !== 16'h3333 || audio_right !== 16'hCCCC || fill_level !== 4'd6) begin
      fails++; $display("FAIL unmute_strobe: got %h/%h fill=%0d want 3333/cccc fill=6",
                        audio_left, audio_right, fill_level);
    end
    wait_strobe(2000, n);
    checks++;
    if (audio_left !== 16'h4444 || fill_level !== 4'd5) begin
      fails++; $display("FAIL after_unmute_strobe: got %h fill=%0d want 4444 fill=5",
                        audio_left, fill_level);
    end
  endtask

  task automatic test_reset_mid;
    int n, m;
    repeat (500) tick();
    checks++;
    if (fill_level !== 4'd5) begin
      fails++; $display("FAIL reset_mid_precond: got fill=%0d want 5", fill_level);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (audio_left !== 16'h0 || audio_right !== 16'h0 || fill_level !== 4'd0 ||
        sample_strobe !== 1'b0 || clk_audio !== 1'b0 || wr_ready !== 1'b1) begin
      fails++; $display("FAIL reset_mid_state: got %h/%h fill=%0d s=%b ca=%b rdy=%b want 0s rdy=1",
                        audio_left, audio_right, fill_level, sample_strobe, clk_audio, wr_ready);
    end
    reset = 1'b0;
    wait_strobe(2000, n);
    checks++;
    if (n !== 1547) begin
      fails++; $display("FAIL reset_mid_first_strobe: got %0d want 1547", n);
    end
    checks++;
    if (underrun_count !== 8'd1 || audio_left !== 16'h0 || fill_level !== 4'd0) begin
      fails++; $display("FAIL reset_mid_discard: got under=%0d L=%h fill=%0d want 1/0/0",
                        underrun_count, audio_left, fill_level);
    end
    m = 0;
    while (!clk_audio && m < 1000) begin
      tick();
      m++;
    end
    checks++;
    if (m !== 774) begin
      fails++; $display("FAIL reset_mid_clk_audio_rise: got %0d want 774", m);
    end
  endtask

  task automatic test_fast_corner;
    f_reset = 1'b1;
    tick();
    f_reset = 1'b0;
    repeat (7) tick();
    checks++;
    if (f_strobe !== 1'b0 || f_ready !== 1'b1) begin
      fails++; $display("FAIL fast_pre_strobe: got s=%b rdy=%b want 0/1", f_strobe, f_ready);
    end
    f_valid = 1'b1; f_left = 16'h1234; f_right = 16'hFEDC;
    tick();
    f_valid = 1'b0;
    checks++;
    if (f_strobe !== 1'b1 || f_under !== 8'd1 || f_fill !== 3'd1 || f_aleft !== 16'h0) begin
      fails++; $display("FAIL fast_push_empty_strobe: got s=%b u=%0d fill=%0d L=%h want 1/1/1/0",
                        f_strobe, f_under, f_fill, f_aleft);
    end
    repeat (7) tick();
    f_valid = 1'b1; f_left = 16'h0BAD; f_right = 16'hF00D;
    tick();
    f_valid = 1'b0;
    checks++;
    if (f_strobe !== 1'b1 || f_fill !== 3'd1 || f_aleft !== 16'h1234 || f_aright !== 16'hFEDC ||
        f_under !== 8'd1) begin
      fails++; $display("FAIL fast_push_pop: got s=%b fill=%0d %h/%h u=%0d want 1/1/1234/fedc/1",
                        f_strobe, f_fill, f_aleft, f_aright, f_under);
    end
    repeat (8) tick();
    checks++;
    if (f_strobe !== 1'b1 || f_fill !== 3'd0 || f_aleft !== 16'h0BAD || f_aright !== 16'hF00D) begin
      fails++; $display("FAIL fast_last_pop: got s=%b fill=%0d %h/%h want 1/0/0bad/f00d",
                        f_strobe, f_fill, f_aleft, f_aright);
    end
  endtask

  task automatic test_underrun_saturation;
    int n, bad;
    bad = 0;
    for (int s = 1; s <= 300; s++) begin
      wait_fstrobe(20, n);
      if (n != 8) bad++;
      if (s == 253) begin
        checks++;
        if (f_under !== 8'd254) begin
          fails++; $display("FAIL sat_254: got %0d want 254", f_under);
        end
      end
      if (s == 254) begin
        checks++;
        if (f_under !== 8'd255) begin
          fails++; $display("FAIL sat_255: got %0d want 255", f_under);
        end
      end
    end
    checks++;
    if (f_under !== 8'd255 || bad !== 0) begin
      fails++; $display("FAIL sat_hold: got %0d bad_spacing=%0d want 255/0", f_under, bad);
    end
    checks++;
    if (f_aleft !== 16'h0BAD || f_aright !== 16'hF00D || f_fill !== 3'd0) begin
      fails++; $display("FAIL sat_outputs_hold: got %h/%h fill=%0d want 0bad/f00d/0", f_aleft,
                        f_aright, f_fill);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_back_to_back();
    test_full_hold();
    test_mute();
    test_reset_mid();
    test_fast_corner();
    test_underrun_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
